ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver: oversamples the keyboard's ps2_clk/ps2_data with the system clock and deframes 11-bit device-to-host frames.
- Folds E0 (extended) and F0 (break) prefixes into 10-bit key events and queues them in a small FIFO.
- Also keeps a live held/released bitmap of the W, A, S, D keys for the player-movement logic.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.
- SYNC_STAGES, 3, flops on ps2_clk/ps2_data before edge detection (min 2).
- TIMEOUT_CYCLES, 50000, idle clk cycles before a partial frame is abandoned (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- clrn  in  1  synchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  in  1  raw PS/2 data from the keyboard, asynchronous.
- rdn  in  1  active-low read strobe; pops the FIFO head.
- data  out  10  FIFO head: [9]=break, [8]=extended, [7:0]=scan code.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky flag: an event was lost because the FIFO was full.
- wsad_down  out  4  held keys: [0]=S(1B), [1]=A(1C), [2]=W(1D), [3]=D(23).

Behaviour:
- Reset (clrn=0 at posedge): pointers/count=0, ready=0, data=0, overflow=0, wsad_down=0, bit counter=0, prefix flags=0, sync chains=1.
- Sampling: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge is a synchronized 1->0 transition on ps2_clk. ps2_data is sampled in the cycle that edge is detected.
- Framing: bit counter 0..10. Fields: start(0), d0..d7 (LSB first), odd parity, stop(1).
- On the 11th edge the frame is valid iff start=0, stop=1, and XOR(d7..d0,parity)=1. Invalid frames are silently dropped.
- Counter returns to 0 after the 11th edge regardless of validity.
- Byte handling for a valid byte B:
  - B=E0: set ext flag; nothing queued.
  - B=F0: set brk flag; nothing queued.
  - Any other B (including E1, AA, FA): event {brk,ext,B}; both flags cleared.
- Event latency: the event is written to the FIFO and wsad_down is updated at the clk edge ending the cycle in which the 11th falling edge is detected. ready/data reflect it on the following cycle.
- wsad_down rules:
  - Only events with ext=0 and code in {1B,1C,1D,23} affect it.
  - brk=0 sets the matching bit; brk=1 clears it. Repeats of a held key are idempotent.
  - Updated even when the FIFO is full.
- FIFO:
  - data is the combinational head word; 0 when empty.
  - Pop when rdn=0 and ready=1 at posedge. rdn=0 while empty is ignored.
  - Holding rdn low drains one entry per cycle.
  - Push while full: event discarded, overflow set.
  - Simultaneous push and pop when full: both succeed, no overflow.
  - overflow clears only on reset.
- Reset mid-frame discards the partial frame and the prefix flags.

Optional Feature:
- Macro PS2_RX_TIMEOUT_EN.
- Defined: a counter tracks cycles since the last detected falling edge. If the bit counter is nonzero and the counter reaches TIMEOUT_CYCLES, the bit counter and prefix flags reset to 0, resynchronizing after glitches or a hot-plug.
- Undefined: no timeout logic; a partial frame waits indefinitely for more edges.

Decomposition:
- Shared package ps2_pkg holds:
  - constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_W=8'h1D, SC_A=8'h1C, SC_S=8'h1B, SC_D=8'h23;
  - wsad bit indices WSAD_S=0, WSAD_A=1, WSAD_W=2, WSAD_D=3;
  - event field positions EVT_BRK=9, EVT_EXT=8.
- One natural sub-module, ps2_evt_fifo: synchronous FIFO with show-ahead head, full/empty, and the overflow flag.

Test Plan:
- Valid frame 1D (make W): ready=1, data=10'h01D, wsad_down=4'b0100.
- F0 then 1D: data=10'h21D, wsad_down[2]=0; F0 alone queues nothing.
- E0 1C, then E0 F0 1C: events 10'h11C and 10'h31C; wsad_down unchanged (extended A ignored).
- Frame 23 with even parity, then a frame with stop=0: nothing queued, wsad_down unchanged. A following valid 23 gives data=10'h023, wsad_down[3]=1.
- Keep rdn=1 and send 9 make codes 15,16,...: first 8 retained, overflow=1. Holding rdn=0 drains 10'h015 first, one per cycle, then ready=0.
- clrn=0 after 5 bits of a frame, then release and send a full valid 1B: data=10'h01B, wsad_down=4'b0001. With PS2_RX_TIMEOUT_EN, 5 bits then an idle gap over TIMEOUT_CYCLES, then 1B: same result.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants for the PS/2 keyboard receiver slice.
//   - Scan codes for the prefix bytes and the four movement keys.
//   - Bit positions of each key inside the wsad_down bitmap.
//   - Field positions of the break/extended flags inside a 10-bit key event.
//   - wsad_mask(): one-hot bitmap bit for a movement key, zero otherwise.
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_W   = 8'h1D;
    localparam logic [7:0] SC_A   = 8'h1C;
    localparam logic [7:0] SC_S   = 8'h1B;
    localparam logic [7:0] SC_D   = 8'h23;

    localparam int WSAD_S = 0;
    localparam int WSAD_A = 1;
    localparam int WSAD_W = 2;
    localparam int WSAD_D = 3;

    localparam int EVT_BRK = 9;
    localparam int EVT_EXT = 8;
    localparam int EVT_W   = 10;

    // Returns the bitmap bit a scan code controls; all zeros for other keys.
    function automatic logic [3:0] wsad_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            SC_S:    m[WSAD_S] = 1'b1;
            SC_A:    m[WSAD_A] = 1'b1;
            SC_W:    m[WSAD_W] = 1'b1;
            SC_D:    m[WSAD_D] = 1'b1;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ---------------------------------------------------------------------------
// ps2_evt_fifo
// Synchronous show-ahead FIFO for key events with a sticky overflow flag.
// Ports:
//   clk      in   system clock
//   clrn     in   synchronous active-low reset
//   push     in   write request for wr_data
//   wr_data  in   DW-bit event word
//   pop_req  in   read request; ignored while empty
//   head     out  oldest entry, zero when empty
//   ready    out  FIFO non-empty
//   overflow out  sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ps2_evt_fifo #(
    parameter int AW = 3,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop_req,
    output logic [DW-1:0] head,
    output logic          ready,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, do_push, do_pop;

    // Next-state logic. A pop frees a slot in the same cycle, so a push into
    // a full FIFO still succeeds when a pop happens alongside it.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop_req & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        ovf_d    = ovf_q | (push & ~do_push);
        head     = empty ? '0 : mem_q[rd_ptr_q];
        ready    = ~empty;
        overflow = ovf_q;
    end

    // State registers; the overflow flag only ever clears on reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver. Oversamples ps2_clk/ps2_data, deframes 11-bit
// device-to-host frames, folds E0/F0 prefixes into 10-bit key events queued
// in a FIFO, and tracks which of W/A/S/D are currently held.
// Ports:
//   clk       in   system clock
//   clrn      in   synchronous active-low reset
//   ps2_clk   in   raw PS/2 clock (asynchronous)
//   ps2_data  in   raw PS/2 data (asynchronous)
//   rdn       in   active-low read strobe, pops the FIFO head
//   data      out  FIFO head: [9]=break, [8]=extended, [7:0]=scan code
//   ready     out  FIFO non-empty
//   overflow  out  sticky lost-event flag
//   wsad_down out  held keys: [0]=S, [1]=A, [2]=W, [3]=D
// Optional build macro PS2_RX_TIMEOUT_EN: abandons a partial frame after
// TIMEOUT_CYCLES clk cycles without a ps2_clk falling edge.
// ---------------------------------------------------------------------------
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rdn,
    output logic [9:0] data,
    output logic       ready,
    output logic       overflow,
    output logic [3:0] wsad_down
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             frame_q, frame_d;
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic [3:0]             wsad_q, wsad_d;
    logic                   fall, dat_bit, frame_done, frame_ok, push, timeout;
    logic [7:0]             rx_byte;
    logic [EVT_W-1:0]       evt_word;

    // Falling edge seen at the output of the synchronizer; data is taken
    // from the same synchronizer depth so both lines stay aligned.
    assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign dat_bit = dat_sync_q[SYNC_STAGES-1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Saturating count of cycles since the last falling edge.
    always_comb begin
        idle_d = idle_q;
        if (fall) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end
        timeout = (bit_cnt_q != 4'd0) && (idle_q == IDLE_MAX);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    // Frame assembly and prefix folding. Bits shift in from the top, so after
    // ten edges frame_q[0] is the start bit, [8:1] the byte, [9] the parity,
    // and the stop bit is the live sample on the eleventh edge.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        frame_done = fall && (bit_cnt_q == 4'd10);
        frame_ok   = ~frame_q[0] & dat_bit & (^frame_q[9:1]);
        rx_byte    = frame_q[8:1];
        evt_word   = {2'b00, rx_byte};
        evt_word[EVT_BRK] = brk_q;
        evt_word[EVT_EXT] = ext_q;
        push      = 1'b0;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        wsad_d    = wsad_q;
        if (fall) begin
            frame_d   = {dat_bit, frame_q[9:1]};
            bit_cnt_d = frame_done ? 4'd0 : bit_cnt_q + 4'd1;
        end
        if (frame_done && frame_ok) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q) begin
                    wsad_d = brk_q ? (wsad_q & ~wsad_mask(rx_byte))
                                   : (wsad_q | wsad_mask(rx_byte));
                end
            end
        end
        if (timeout) begin
            bit_cnt_d = 4'd0;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
        end
    end

    // Receiver state. Sync chains reset to the idle-high line level so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            frame_q    <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            wsad_q     <= 4'b0000;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            wsad_q     <= wsad_d;
        end
    end

    assign wsad_down = wsad_q;

    ps2_evt_fifo #(
        .AW (FIFO_AW),
        .DW (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .push     (push),
        .wr_data  (evt_word),
        .pop_req  (~rdn),
        .head     (data),
        .ready    (ready),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Drives PS/2 frames into ps2_kbd_rx, predicts key events and the W/A/S/D
// bitmap with a small reference model, and drains the FIFO against a
// scoreboard queue. Define PS2_RX_TIMEOUT_EN to include the timeout test.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int HALF = 15;
    localparam int TMO  = 3000;

    logic       clk      = 1'b0;
    logic       clrn     = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rdn      = 1'b1;
    logic [9:0] data;
    logic       ready;
    logic       overflow;
    logic [3:0] wsad_down;

    int         checks   = 0;
    int         failures = 0;
    logic [9:0] sb[$];
    logic       m_ext  = 1'b0;
    logic       m_brk  = 1'b0;
    logic       m_ovf  = 1'b0;
    logic [3:0] m_wsad = 4'b0000;

    ps2_kbd_rx #(
        .FIFO_AW        (3),
        .SYNC_STAGES    (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rdn       (rdn),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .wsad_down (wsad_down)
    );

    always #5 clk = ~clk;

    // Reference model of one received valid byte: prefix folding, FIFO
    // capacity (the bench never pops while sending) and the key bitmap.
    task automatic model_byte(input logic [7:0] b);
        logic [9:0] evt;
        int         idx;
        if (b == SC_EXT) begin
            m_ext = 1'b1;
        end else if (b == SC_BRK) begin
            m_brk = 1'b1;
        end else begin
            evt          = {2'b00, b};
            evt[EVT_BRK] = m_brk;
            evt[EVT_EXT] = m_ext;
            if (sb.size() < 8) sb.push_back(evt);
            else m_ovf = 1'b1;
            if (!m_ext) begin
                case (b)
                    SC_S:    idx = WSAD_S;
                    SC_A:    idx = WSAD_A;
                    SC_W:    idx = WSAD_W;
                    SC_D:    idx = WSAD_D;
                    default: idx = -1;
                endcase
                if (idx >= 0) m_wsad[idx] = ~m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Sends the first nbits of a frame for byte b, optionally corrupting
    // parity or the stop bit, then idles long enough for the event to land.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par,
                                 input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (2 * HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        applyStimulus(b, 1'b0, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready);
        end
        checks++;
        if (data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 000", data);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
        end
        checks++;
        if (wsad_down !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_wsad: got %b expected 0000", wsad_down);
        end
        clrn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_make_w();
        send_byte(SC_W);
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL make_w_wsad: got %b expected %b", wsad_down, m_wsad);
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            if (ready !== 1'b1 || data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL make_w_event: ready=%b data=%h expected ready=1 data=%h", ready, data, sb[0]);
            end
            void'(sb.pop_front());
            rdn = 1'b0;
            @(negedge clk);
        end
        rdn = 1'b1;
        checks++;
        if (ready !== 1'b0 || data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL make_w_empty: ready=%b data=%h expected 0/000", ready, data);
        end
    endtask

    task automatic test_break();
        send_byte(SC_BRK);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL break_prefix_alone: ready=%b expected 0", ready);
        end
        send_byte(SC_W);
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL break_wsad: got %b expected %b", wsad_down, m_wsad);
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            if (ready !== 1'b1 || data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL break_event: ready=%b data=%h expected ready=1 data=%h", ready, data, sb[0]);
            end
            void'(sb.pop_front());
            rdn = 1'b0;
            @(negedge clk);
        end
        rdn = 1'b1;
        checks++;
        if (ready !== 1'b0 || data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL break_empty: ready=%b data=%h expected 0/000", ready, data);
        end
    endtask

    task automatic test_extended();
        send_byte(SC_A);
        send_byte(SC_EXT);
        send_byte(SC_A);
        send_byte(SC_EXT);
        send_byte(SC_BRK);
        send_byte(SC_A);
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL ext_wsad_held: got %b expected %b", wsad_down, m_wsad);
        end
        send_byte(SC_BRK);
        send_byte(SC_A);
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL ext_wsad_released: got %b expected %b", wsad_down, m_wsad);
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            if (ready !== 1'b1 || data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL ext_event: ready=%b data=%h expected ready=1 data=%h", ready, data, sb[0]);
            end
            void'(sb.pop_front());
            rdn = 1'b0;
            @(negedge clk);
        end
        rdn = 1'b1;
        checks++;
        if (ready !== 1'b0 || data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL ext_empty: ready=%b data=%h expected 0/000", ready, data);
        end
    endtask

    task automatic test_bad_frames();
        applyStimulus(SC_D, 1'b1, 1'b0, 11);
        applyStimulus(SC_D, 1'b0, 1'b1, 11);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bad_frame_queued: ready=%b expected 0", ready);
        end
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL bad_frame_wsad: got %b expected %b", wsad_down, m_wsad);
        end
        send_byte(SC_D);
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL good_d_wsad: got %b expected %b", wsad_down, m_wsad);
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            if (ready !== 1'b1 || data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL good_d_event: ready=%b data=%h expected ready=1 data=%h", ready, data, sb[0]);
            end
            void'(sb.pop_front());
            rdn = 1'b0;
            @(negedge clk);
        end
        rdn = 1'b1;
        checks++;
        if (ready !== 1'b0 || data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL good_d_empty: ready=%b data=%h expected 0/000", ready, data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h15 + 8'(i));
        end
        checks++;
        if (overflow !== m_ovf) begin
            failures++;
            $display("[TB] FAIL overflow_flag: got %b expected %b", overflow, m_ovf);
        end
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL overflow_wsad: got %b expected %b", wsad_down, m_wsad);
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            if (ready !== 1'b1 || data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL drain_event: ready=%b data=%h expected ready=1 data=%h", ready, data, sb[0]);
            end
            void'(sb.pop_front());
            rdn = 1'b0;
            @(negedge clk);
        end
        rdn = 1'b1;
        checks++;
        if (ready !== 1'b0 || data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL drain_empty: ready=%b data=%h expected 0/000", ready, data);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_reset_midframe();
        applyStimulus(SC_S, 1'b0, 1'b0, 5);
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn   = 1'b1;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_ovf  = 1'b0;
        m_wsad = 4'b0000;
        sb.delete();
        checks++;
        if (overflow !== 1'b0 || wsad_down !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midreset_state: overflow=%b wsad=%b expected 0/0000", overflow, wsad_down);
        end
        send_byte(SC_S);
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL midreset_wsad: got %b expected %b", wsad_down, m_wsad);
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            if (ready !== 1'b1 || data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL midreset_event: ready=%b data=%h expected ready=1 data=%h", ready, data, sb[0]);
            end
            void'(sb.pop_front());
            rdn = 1'b0;
            @(negedge clk);
        end
        rdn = 1'b1;
        checks++;
        if (ready !== 1'b0 || data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL midreset_empty: ready=%b data=%h expected 0/000", ready, data);
        end
    endtask

`ifdef PS2_RX_TIMEOUT_EN
    task automatic test_timeout();
        send_byte(SC_BRK);
        sb.delete();
        applyStimulus(SC_S, 1'b0, 1'b0, 5);
        repeat (TMO + 500) @(negedge clk);
        m_brk = 1'b0;
        m_ext = 1'b0;
        send_byte(SC_S);
        checks++;
        if (wsad_down !== m_wsad) begin
            failures++;
            $display("[TB] FAIL timeout_wsad: got %b expected %b", wsad_down, m_wsad);
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            if (ready !== 1'b1 || data !== sb[0]) begin
                failures++;
                $display("[TB] FAIL timeout_event: ready=%b data=%h expected ready=1 data=%h", ready, data, sb[0]);
            end
            void'(sb.pop_front());
            rdn = 1'b0;
            @(negedge clk);
        end
        rdn = 1'b1;
        checks++;
        if (ready !== 1'b0 || data !== 10'h000) begin
            failures++;
            $display("[TB] FAIL timeout_empty: ready=%b data=%h expected 0/000", ready, data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_make_w();
        test_break();
        test_extended();
        test_bad_frames();
        test_overflow();
        test_reset_midframe();
`ifdef PS2_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
